// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operation sequencer and the ALU it drives.
//   state_t : 2-bit sequencer state encoding
//   FN_*    : ALU operation codes presented on the Function bus
package alu_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD_B = 2'd1,
    S_EXEC   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [1:0] FN_ADD = 2'b00;
  localparam logic [1:0] FN_OR  = 2'b01;
  localparam logic [1:0] FN_AND = 2'b10;
  localparam logic [1:0] FN_CAT = 2'b11;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for a level input such as a push key.
// Ports:
//   Clock : system clock, rising edge
//   Reset : synchronous active-high reset, clears the history bit
//   in    : level input
//   pulse : high for the cycle in which in=1 and the previous sample was 0
module rise_detect (
  input  logic Clock,
  input  logic Reset,
  input  logic in,
  output logic pulse
);

  logic prev_q;

  always_ff @(posedge Clock) begin
    if (Reset) prev_q <= 1'b0;
    else       prev_q <= in;
  end

  // History cleared by reset, so a level held through reset release
  // still produces one pulse in the first cycle afterwards.
  assign pulse = in & ~prev_q;

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences one ALU operation per pair of Go presses: first press loads A,
// second loads B and the op code, then the ALU result is captured one clock
// later and Done pulses for one cycle.
// Ports:
//   Clock, Reset : system clock, synchronous active-high reset
//   Data, Func   : operand switches and requested op code
//   Go           : key level; only rising edges act
//   Acc          : at B-load, take B from the low half of Result
//   ALUout_in    : result from the downstream ALU
//   A, B, Function : registered operands and op code to the ALU
//   Result, Done, Busy, OpCount : captured result, completion pulse,
//                  activity flag, completed-operation count (mod 256)
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int N = 4
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic [N-1:0]   Data,
  input  logic [1:0]     Func,
  input  logic           Go,
  input  logic           Acc,
  input  logic [2*N-1:0] ALUout_in,
  output logic [N-1:0]   A,
  output logic [N-1:0]   B,
  output logic [1:0]     Function,
  output logic [2*N-1:0] Result,
  output logic           Done,
  output logic           Busy,
  output logic [7:0]     OpCount
);

  state_t         state_q;
  logic [N-1:0]   a_q, b_q;
  logic [1:0]     fn_q;
  logic [2*N-1:0] result_q;
  logic [7:0]     opcount_q;
  logic           done_q, busy_q;
  logic           go_edge;
  logic [N-1:0]   b_d;

  rise_detect u_go_edge (
    .Clock (Clock),
    .Reset (Reset),
    .in    (Go),
    .pulse (go_edge)
  );

  // Accumulate mode chains the previous result's low half into B.
  assign b_d = Acc ? result_q[N-1:0] : Data;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      fn_q      <= '0;
      result_q  <= '0;
      opcount_q <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (go_edge) begin
            a_q     <= Data;
            state_q <= S_LOAD_B;
            busy_q  <= 1'b1;
          end
        end
        S_LOAD_B: begin
          if (go_edge) begin
            b_q     <= b_d;
            fn_q    <= Func;
            state_q <= S_EXEC;
          end
        end
        // The ALU has had one full cycle with stable A/B/Function.
        S_EXEC: begin
          result_q  <= ALUout_in;
          opcount_q <= opcount_q + 8'd1;
          done_q    <= 1'b1;
          state_q   <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign A        = a_q;
  assign B        = b_q;
  assign Function = fn_q;
  assign Result   = result_q;
  assign Done     = done_q;
  assign Busy     = busy_q;
  assign OpCount  = opcount_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;
  import alu_pkg::*;

  localparam int N = 4;

  logic           Clock;
  logic           Reset;
  logic [N-1:0]   Data;
  logic [1:0]     Func;
  logic           Go;
  logic           Acc;
  logic [2*N-1:0] ALUout_in;
  logic [N-1:0]   A, B;
  logic [1:0]     Function;
  logic [2*N-1:0] Result;
  logic           Done, Busy;
  logic [7:0]     OpCount;

  int checks = 0;
  int errors = 0;

  // Reference model: operation-level view of what the sequencer holds.
  logic [N-1:0]   m_a, m_b;
  logic [1:0]     m_fn;
  logic [2*N-1:0] m_res;
  int             m_cnt;

  alu_op_sequencer #(.N(N)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Data      (Data),
    .Func      (Func),
    .Go        (Go),
    .Acc       (Acc),
    .ALUout_in (ALUout_in),
    .A         (A),
    .B         (B),
    .Function  (Function),
    .Result    (Result),
    .Done      (Done),
    .Busy      (Busy),
    .OpCount   (OpCount)
  );

  function automatic logic [2*N-1:0] alu_ref(input logic [N-1:0] a, input logic [N-1:0] b,
                                             input logic [1:0] fn);
    logic [2*N-1:0] r;
    case (fn)
      FN_ADD:  r = {{N{1'b0}}, a} + {{N{1'b0}}, b};
      FN_OR:   r = {{N{1'b0}}, a | b};
      FN_AND:  r = {{N{1'b0}}, a & b};
      default: r = {a, b};
    endcase
    return r;
  endfunction

  // Downstream ALU stand-in.
  assign ALUout_in = alu_ref(A, B, Function);

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic model_reset();
    m_a = '0; m_b = '0; m_fn = '0; m_res = '0; m_cnt = 0;
  endtask

  // Drives one complete operation and reports the observed handshake.
  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic [1:0] fn,
                       input logic acc, output logic done_hi, output logic done_lo,
                       output logic busy_all, output logic busy_end);
    busy_all = 1'b1;
    Go = 1'b0; Data = a; Acc = 1'($urandom); tick();
    Go = 1'b1; tick(); busy_all &= Busy;
    Go = 1'b0; Data = b; Func = fn; Acc = acc; tick(); busy_all &= Busy;
    Go = 1'b1; tick(); busy_all &= Busy;
    Go = 1'b0; Acc = ~acc; Data = N'($urandom); tick(); busy_all &= Busy; done_hi = Done;
    tick(); done_lo = Done; busy_end = Busy;
    m_b   = acc ? m_res[N-1:0] : b;
    m_a   = a;
    m_fn  = fn;
    m_res = alu_ref(m_a, m_b, m_fn);
    m_cnt = (m_cnt + 1) % 256;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Go = 1'b1; Data = 4'h9; Func = 2'b11; Acc = 1'b1;
    tick(); tick();
    model_reset();
    checks++; if ({A, B, Function} !== '0) begin errors++;
      $display("FAIL reset_abf: got %h expected 0", {A, B, Function}); end
    checks++; if (Result !== '0) begin errors++;
      $display("FAIL reset_result: got %h expected 0", Result); end
    checks++; if (OpCount !== 8'd0) begin errors++;
      $display("FAIL reset_opcount: got %0d expected 0", OpCount); end
    checks++; if ({Done, Busy} !== 2'b00) begin errors++;
      $display("FAIL reset_done_busy: got %b expected 00", {Done, Busy}); end
    // Go held across reset release counts as one edge.
    Reset = 1'b0; tick();
    checks++; if (A !== 4'h9 || Busy !== 1'b1) begin errors++;
      $display("FAIL go_across_reset: got A=%h Busy=%b expected A=9 Busy=1", A, Busy); end
    Data = 4'h3; tick(); tick();
    checks++; if (A !== 4'h9 || B !== 4'h0 || Done !== 1'b0) begin errors++;
      $display("FAIL go_held_after_reset: got A=%h B=%h Done=%b expected A=9 B=0 Done=0", A, B, Done); end
    Reset = 1'b1; Go = 1'b0; tick();
    Reset = 1'b0; tick();
    checks++; if (Busy !== 1'b0 || A !== 4'h0) begin errors++;
      $display("FAIL reset_in_load_b: got Busy=%b A=%h expected Busy=0 A=0", Busy, A); end
  endtask

  task automatic test_add();
    logic dh, dl, ba, be;
    do_op(4'd3, 4'd5, FN_ADD, 1'b0, dh, dl, ba, be);
    checks++; if (Result !== 8'h08) begin errors++;
      $display("FAIL add_result: got %h expected 08", Result); end
    checks++; if (dh !== 1'b1 || dl !== 1'b0) begin errors++;
      $display("FAIL add_done_pulse: got %b%b expected 10", dh, dl); end
    checks++; if (OpCount !== 8'd1) begin errors++;
      $display("FAIL add_opcount: got %0d expected 1", OpCount); end
  endtask

  task automatic test_acc();
    logic dh, dl, ba, be;
    do_op(4'd2, 4'hF, FN_ADD, 1'b1, dh, dl, ba, be);
    checks++; if (B !== 4'h8) begin errors++;
      $display("FAIL acc_b: got %h expected 8", B); end
    checks++; if (Result !== 8'h0A) begin errors++;
      $display("FAIL acc_result: got %h expected 0a", Result); end
  endtask

  task automatic test_cat();
    logic dh, dl, ba, be;
    do_op(4'hA, 4'h5, FN_CAT, 1'b0, dh, dl, ba, be);
    checks++; if (Result !== 8'hA5) begin errors++;
      $display("FAIL cat_result: got %h expected a5", Result); end
    checks++; if (ba !== 1'b1 || be !== 1'b0) begin errors++;
      $display("FAIL cat_busy: got during=%b after=%b expected 1 0", ba, be); end
    checks++; if (Function !== FN_CAT || A !== 4'hA || B !== 4'h5) begin errors++;
      $display("FAIL cat_hold_inputs: got %h %h %h expected 3 a 5", Function, A, B); end
  endtask

  task automatic test_go_held();
    Go = 1'b0; Data = 4'h7; tick();
    Go = 1'b1; tick();
    checks++; if (A !== 4'h7 || Busy !== 1'b1) begin errors++;
      $display("FAIL held_first_edge: got A=%h Busy=%b expected 7 1", A, Busy); end
    for (int i = 0; i < 4; i++) begin
      Data = N'($urandom); tick();
    end
    checks++; if (A !== 4'h7 || B !== m_b || Busy !== 1'b1 || Done !== 1'b0) begin errors++;
      $display("FAIL held_single_edge: got A=%h B=%h Busy=%b Done=%b expected A=7 B=%h Busy=1 Done=0",
               A, B, Busy, Done, m_b); end
    Go = 1'b0; Data = 4'h2; Func = FN_OR; Acc = 1'b0; tick();
    Go = 1'b1; tick();
    Go = 1'b0; tick();
    checks++; if (Done !== 1'b1) begin errors++;
      $display("FAIL held_done: got %b expected 1", Done); end
    Go = 1'b1; Data = 4'hC; tick(); tick();
    checks++; if (Busy !== 1'b0 || A !== 4'h7) begin errors++;
      $display("FAIL edge_in_done_ignored: got Busy=%b A=%h expected 0 7", Busy, A); end
    Go = 1'b0; tick();
    m_a = 4'h7; m_b = 4'h2; m_fn = FN_OR; m_res = alu_ref(m_a, m_b, m_fn);
    m_cnt = (m_cnt + 1) % 256;
    checks++; if (Result !== m_res || OpCount !== 8'(m_cnt)) begin errors++;
      $display("FAIL held_result: got %h/%0d expected %h/%0d", Result, OpCount, m_res, m_cnt); end
  endtask

  task automatic test_reset_exec();
    Go = 1'b0; Data = 4'h1; tick();
    Go = 1'b1; tick();
    Go = 1'b0; Data = 4'h6; Func = FN_ADD; Acc = 1'b0; tick();
    Go = 1'b1; tick();
    Reset = 1'b1; Go = 1'b0; tick();
    model_reset();
    checks++; if ({A, B, Function, Result, OpCount, Done, Busy} !== '0) begin errors++;
      $display("FAIL reset_exec_outputs: got A=%h B=%h F=%h R=%h C=%0d D=%b Bz=%b expected all 0",
               A, B, Function, Result, OpCount, Done, Busy); end
    Reset = 1'b0; tick();
    checks++; if (Done !== 1'b0 || Busy !== 1'b0 || Result !== '0) begin errors++;
      $display("FAIL reset_exec_no_done: got D=%b Bz=%b R=%h expected 0 0 00", Done, Busy, Result); end
  endtask

  task automatic test_random();
    logic dh, dl, ba, be;
    for (int i = 0; i < 24; i++) begin
      do_op(N'($urandom), N'($urandom), 2'($urandom), 1'($urandom), dh, dl, ba, be);
      checks++;
      if (A !== m_a || B !== m_b || Function !== m_fn || Result !== m_res ||
          OpCount !== 8'(m_cnt) || dh !== 1'b1 || dl !== 1'b0 || ba !== 1'b1 || be !== 1'b0) begin
        errors++;
        $display("FAIL random_op%0d: got A=%h B=%h F=%h R=%h C=%0d D=%b%b Bz=%b%b expected A=%h B=%h F=%h R=%h C=%0d D=10 Bz=10",
                 i, A, B, Function, Result, OpCount, dh, dl, ba, be, m_a, m_b, m_fn, m_res, m_cnt);
      end
    end
  endtask

  task automatic test_wrap();
    logic dh, dl, ba, be;
    int bad = 0;
    Reset = 1'b1; Go = 1'b0; tick();
    Reset = 1'b0; model_reset(); tick();
    for (int i = 0; i < 256; i++) begin
      do_op(N'($urandom), N'($urandom), 2'($urandom), 1'($urandom), dh, dl, ba, be);
      if (Result !== m_res || dh !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++;
      $display("FAIL wrap_results: got %0d bad operations expected 0", bad); end
    checks++; if (OpCount !== 8'd0) begin errors++;
      $display("FAIL wrap_256: got %0d expected 0", OpCount); end
    do_op(N'($urandom), N'($urandom), 2'($urandom), 1'b0, dh, dl, ba, be);
    checks++; if (OpCount !== 8'd1 || Result !== m_res) begin errors++;
      $display("FAIL wrap_257: got %0d/%h expected 1/%h", OpCount, Result, m_res); end
  endtask

  initial begin
    Reset = 1'b1; Go = 1'b0; Data = '0; Func = '0; Acc = 1'b0;
    model_reset();
    test_reset();
    test_add();
    test_acc();
    test_cat();
    test_go_held();
    test_reset_exec();
    test_random();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
